// File: rtl/issue_stage.sv
// In-order decode/issue stage: a decode slot (D) feeding a registered execute slot (X),
// with a per-register pending-write scoreboard blocking RAW and WAW hazards.
module issue_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INSTR_WIDTH-1:0]           in_instr,
    input  logic [31:0]                      in_pc,
    output logic [1:0][ADDR_WIDTH-1:0]       rf_read_addrs,
    input  logic [1:0][DATA_WIDTH-1:0]       rf_read_data,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INSTR_WIDTH-1:0]           out_instr,
    output logic [31:0]                      out_pc,
    output logic [DATA_WIDTH-1:0]            out_rs1_data,
    output logic [DATA_WIDTH-1:0]            out_rs2_data,
    output logic [ADDR_WIDTH-1:0]            out_rd,
    output logic                             out_rd_we,
    output logic [31:0]                      stall_count
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // Decode slot
    logic                   d_valid_q, d_valid_d;
    logic [INSTR_WIDTH-1:0] d_instr_q, d_instr_d;
    logic [31:0]            d_pc_q, d_pc_d;

    // Execute (output) slot
    logic                   x_valid_q, x_valid_d;
    logic [INSTR_WIDTH-1:0] x_instr_q, x_instr_d;
    logic [31:0]            x_pc_q, x_pc_d;
    logic [DATA_WIDTH-1:0]  x_rs1_q, x_rs1_d;
    logic [DATA_WIDTH-1:0]  x_rs2_q, x_rs2_d;
    logic [ADDR_WIDTH-1:0]  x_rd_q, x_rd_d;
    logic                   x_rd_we_q, x_rd_we_d;

    logic [NUM_REGS-1:0]    pending_q, pending_d;
    logic [31:0]            stall_q, stall_d;

    logic [6:0]             d_opcode;
    logic [ADDR_WIDTH-1:0]  d_rd, d_rs1, d_rs2;
    logic                   d_uses_rs1, d_uses_rs2, d_rd_we;
    logic                   haz_rs1, haz_rs2, haz_waw, hazard, issue, accept;

    // Decode the D slot and evaluate hazards against the scoreboard and the X slot
    always_comb begin
        d_opcode   = d_instr_q[6:0];
        d_rd       = d_instr_q[7 +: ADDR_WIDTH];
        d_rs1      = d_instr_q[15 +: ADDR_WIDTH];
        d_rs2      = d_instr_q[20 +: ADDR_WIDTH];
        d_uses_rs1 = !(d_opcode inside {OpLui, OpAuipc, OpJal});
        d_uses_rs2 = d_opcode inside {OpReg, OpStore, OpBranch};
        d_rd_we    = !(d_opcode inside {OpStore, OpBranch}) && (d_rd != '0);
        // X still counts as an in-flight writer until its handoff sets the scoreboard bit
        haz_rs1    = d_uses_rs1 && (d_rs1 != '0) &&
                     (pending_q[d_rs1] || (x_valid_q && x_rd_we_q && (x_rd_q == d_rs1)));
        haz_rs2    = d_uses_rs2 && (d_rs2 != '0) &&
                     (pending_q[d_rs2] || (x_valid_q && x_rd_we_q && (x_rd_q == d_rs2)));
        haz_waw    = d_rd_we &&
                     (pending_q[d_rd] || (x_valid_q && x_rd_we_q && (x_rd_q == d_rd)));
        hazard     = haz_rs1 || haz_rs2 || haz_waw;
        issue      = d_valid_q && !hazard && (!x_valid_q || out_ready);
        // Gated by rst_n so the stage refuses input while held in reset
        in_ready   = rst_n && (!d_valid_q || issue) && !flush;
        accept     = in_valid && in_ready;
    end

    // Next-state for both slots, the scoreboard and the stall counter
    always_comb begin
        d_valid_d = d_valid_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        x_valid_d = x_valid_q;
        x_instr_d = x_instr_q;
        x_pc_d    = x_pc_q;
        x_rs1_d   = x_rs1_q;
        x_rs2_d   = x_rs2_q;
        x_rd_d    = x_rd_q;
        x_rd_we_d = x_rd_we_q;
        pending_d = pending_q;
        stall_d   = stall_q;

        if (flush) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = in_instr;
            d_pc_d    = in_pc;
        end else if (issue) begin
            d_valid_d = 1'b0;
        end

        if (flush) begin
            x_valid_d = 1'b0;
        end else if (issue) begin
            x_valid_d = 1'b1;
            x_instr_d = d_instr_q;
            x_pc_d    = d_pc_q;
            x_rs1_d   = d_uses_rs1 ? rf_read_data[0] : '0;
            x_rs2_d   = d_uses_rs2 ? rf_read_data[1] : '0;
            x_rd_d    = d_rd;
            x_rd_we_d = d_rd_we;
        end else if (out_ready) begin
            x_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set on the same register wins
        if (wb_valid && (wb_addr != '0)) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (x_valid_q && out_ready && x_rd_we_q) begin
            pending_d[x_rd_q] = 1'b1;
        end

        if (d_valid_q && hazard && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
            d_pc_q    <= '0;
            x_valid_q <= 1'b0;
            x_instr_q <= '0;
            x_pc_q    <= '0;
            x_rs1_q   <= '0;
            x_rs2_q   <= '0;
            x_rd_q    <= '0;
            x_rd_we_q <= 1'b0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            x_valid_q <= x_valid_d;
            x_instr_q <= x_instr_d;
            x_pc_q    <= x_pc_d;
            x_rs1_q   <= x_rs1_d;
            x_rs2_q   <= x_rs2_d;
            x_rd_q    <= x_rd_d;
            x_rd_we_q <= x_rd_we_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    assign rf_read_addrs[0] = d_rs1;
    assign rf_read_addrs[1] = d_rs2;
    assign out_valid        = x_valid_q;
    assign out_instr        = x_instr_q;
    assign out_pc           = x_pc_q;
    assign out_rs1_data     = x_rs1_q;
    assign out_rs2_data     = x_rs2_q;
    assign out_rd           = x_rd_q;
    assign out_rd_we        = x_rd_we_q;
    assign stall_count      = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: independent stream, RAW stall, x0/unused sources,
// backpressure, flush and asynchronous reset mid-stall.
module tb_issue_stage;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic [1:0][4:0]  rf_read_addrs;
    logic [1:0][31:0] rf_read_data;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [31:0]      out_pc;
    logic [31:0]      out_rs1_data;
    logic [31:0]      out_rs2_data;
    logic [4:0]       out_rd;
    logic             out_rd_we;
    logic [31:0]      stall_count;

    logic [31:0] regs [0:31];
    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] New5 = 32'hCAFE_0005;
    // lui x7 with bits [19:15] = 5
    localparam logic [31:0] Lui7 = {12'h000, 5'd5, 3'b000, 5'd7, 7'b0110111};

    issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_read_addrs(rf_read_addrs),
        .rf_read_data (rf_read_data),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read
    always_comb begin
        rf_read_data[0] = regs[rf_read_addrs[0]];
        rf_read_data[1] = regs[rf_read_addrs[1]];
    end

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'h100 + k;
        regs[0]   = 32'h0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stall", stall_count, 0);
        check("rst_rd", out_rd, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Independent stream
        in_valid = 1'b1; in_instr = enc_i(5'd1, 5'd0, 12'd5); in_pc = 32'h1000; #1;
        check("rel_in_ready", in_ready, 1);
        tick();
        in_instr = enc_i(5'd2, 5'd0, 12'd7); in_pc = 32'h1004; #1;
        check("ind_latency", out_valid, 0);
        check("ind_in_ready", in_ready, 1);
        tick();
        in_instr = enc_r(7'd0, 5'd5, 5'd4, 5'd3); in_pc = 32'h1008; #1;
        check("ind_valid1", out_valid, 1);
        check("ind_rd1", out_rd, 1);
        check("ind_rd_we1", out_rd_we, 1);
        check("ind_instr1", out_instr, enc_i(5'd1, 5'd0, 12'd5));
        tick();
        in_valid = 1'b0; #1;
        check("ind_valid2", out_valid, 1);
        check("ind_rd2", out_rd, 2);
        check("ind_rf_addr0", {27'd0, rf_read_addrs[0]}, 4);
        check("ind_rf_addr1", {27'd0, rf_read_addrs[1]}, 5);
        tick();
        check("ind_valid3", out_valid, 1);
        check("ind_rd3", out_rd, 3);
        check("ind_rs1", out_rs1_data, 32'h104);
        check("ind_rs2", out_rs2_data, 32'h105);
        check("ind_pc3", out_pc, 32'h1008);
        check("ind_stall", stall_count, 0);
        tick();
        check("ind_empty", out_valid, 0);
        wb_valid = 1'b1; wb_addr = 5'd1; tick();
        wb_addr = 5'd2; tick();
        wb_addr = 5'd3; tick();
        wb_valid = 1'b0;

        // RAW: add x5,x1,x2 then sub x6,x5,x3; wb x5 three cycles after handoff
        in_valid = 1'b1; in_instr = enc_r(7'd0, 5'd2, 5'd1, 5'd5); in_pc = 32'h2000;
        tick();
        in_instr = enc_r(7'h20, 5'd3, 5'd5, 5'd6); in_pc = 32'h2004; #1;
        check("raw_accept", in_ready, 1);
        tick();
        in_valid = 1'b0; #1;
        check("raw_prod_valid", out_valid, 1);
        check("raw_prod_rd", out_rd, 5);
        check("raw_blocked", in_ready, 0);
        tick();
        check("raw_drain", out_valid, 0);
        tick();
        tick();
        wb_valid = 1'b1; wb_addr = 5'd5; #1;
        check("raw_wb_stall", out_valid, 0);
        tick();
        wb_valid = 1'b0; regs[5] = New5; #1;
        check("raw_no_bypass", out_valid, 0);
        tick();
        check("raw_issue", out_valid, 1);
        check("raw_rd", out_rd, 6);
        check("raw_rs1_new", out_rs1_data, New5);
        check("raw_rs2", out_rs2_data, 32'h103);
        check("raw_stall", stall_count, 4);
        tick();

        // x0 and unused sources: set pending[5], then lui x7 and addi x8,x0
        in_valid = 1'b1; in_instr = enc_r(7'd0, 5'd2, 5'd1, 5'd5); in_pc = 32'h3000;
        tick();
        in_valid = 1'b0; tick();
        tick();
        in_valid = 1'b1; in_instr = Lui7; in_pc = 32'h3004; tick();
        in_instr = enc_i(5'd8, 5'd0, 12'd3); in_pc = 32'h3008; #1;
        check("lui_no_stall", in_ready, 1);
        tick();
        in_valid = 1'b0; #1;
        check("lui_valid", out_valid, 1);
        check("lui_rd", out_rd, 7);
        check("lui_rs1_zero", out_rs1_data, 0);
        check("lui_rs2_zero", out_rs2_data, 0);
        tick();
        check("x0_valid", out_valid, 1);
        check("x0_rd", out_rd, 8);
        check("x0_stall", stall_count, 4);
        tick();

        // Backpressure: out_ready low for 5 cycles, 3 instructions offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_i(5'd10, 5'd0, 12'd1); in_pc = 32'h4000; tick();
        in_instr = enc_i(5'd11, 5'd0, 12'd2); in_pc = 32'h4004; tick();
        in_instr = enc_i(5'd12, 5'd0, 12'd3); in_pc = 32'h4008; #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_rd", out_rd, 10);
        tick();
        check("bp_hold_instr", out_instr, enc_i(5'd10, 5'd0, 12'd1));
        check("bp_hold_ready", in_ready, 0);
        tick();
        check("bp_hold_pc", out_pc, 32'h4000);
        tick();
        out_ready = 1'b1; #1;
        check("bp_rel_ready", in_ready, 1);
        check("bp_rel_rd", out_rd, 10);
        tick();
        in_valid = 1'b0; #1;
        check("bp_order2", out_rd, 11);
        check("bp_valid2", out_valid, 1);
        tick();
        check("bp_order3", out_rd, 12);
        check("bp_stall", stall_count, 4);
        tick();

        // Flush with D and X full
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_i(5'd9, 5'd0, 12'd1); in_pc = 32'h5000; tick();
        in_instr = enc_i(5'd13, 5'd0, 12'd1); in_pc = 32'h5004; tick();
        in_instr = enc_i(5'd14, 5'd0, 12'd1); flush = 1'b1; #1;
        check("fl_pre_valid", out_valid, 1);
        check("fl_pre_rd", out_rd, 9);
        check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        check("fl_x_empty", out_valid, 0);
        tick();
        check("fl_d_empty", out_valid, 0);
        in_valid = 1'b1; in_instr = enc_r(7'd0, 5'd0, 5'd9, 5'd15); in_pc = 32'h5008;
        tick();
        in_valid = 1'b0; tick();
        check("fl_pend9_clear", out_valid, 1);
        check("fl_probe_rd", out_rd, 15);
        check("fl_stall", stall_count, 4);
        tick();

        // Async reset while a WAW-stalled addi x5 sits in D
        in_valid = 1'b1; in_instr = enc_i(5'd5, 5'd0, 12'd9); in_pc = 32'h6000; tick();
        in_valid = 1'b0; #1;
        check("waw_blocked", in_ready, 0);
        tick();
        check("waw_stall", stall_count, 5);
        check("waw_no_out", out_valid, 0);
        rst_n = 1'b0; #1;
        check("ar_stall", stall_count, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_rf_addr1", {27'd0, rf_read_addrs[1]}, 0);
        check("ar_out_valid", out_valid, 0);
        tick();
        tick();
        rst_n = 1'b1; #1;
        check("ar_rel_ready", in_ready, 1);
        in_valid = 1'b1; in_instr = enc_r(7'd0, 5'd6, 5'd5, 5'd16); in_pc = 32'h7000;
        tick();
        in_valid = 1'b0; tick();
        check("ar_sb_clear", out_valid, 1);
        check("ar_rd", out_rd, 16);
        check("ar_rs1", out_rs1_data, New5);
        check("ar_rs2", out_rs2_data, 32'h106);
        check("ar_stall_zero", stall_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
# issue_stage

In-order decode/issue stage sitting directly upstream of the register file. Accepts instructions from fetch and drives the RF read ports from the instruction's source fields. It blocks RAW and WAW hazards with a per-register pending-write scoreboard. It presents operands plus destination info to execute through a registered valid/ready output slot.

## Interface
- DATA_WIDTH, 32, register/operand width
- NUM_REGS, 32, architectural registers; x0 hardwired zero
- ADDR_WIDTH, $clog2(NUM_REGS), register index width
- INSTR_WIDTH, 32, instruction width (RV32 field layout)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_WIDTH  instruction word
- in_pc  in  32  instruction PC
- rf_read_addrs  out  ADDR_WIDTH x2  [0]=rs1, [1]=rs2 of decode slot
- rf_read_data  in  DATA_WIDTH x2  combinational RF read data
- wb_valid  in  1  writeback retiring a register write
- wb_addr  in  ADDR_WIDTH  register being written by writeback
- flush  in  1  kill all instructions held in this stage
- out_valid  out  1  execute slot holds an instruction
- out_ready  in  1  execute consumes
- out_instr, out_pc  out  INSTR_WIDTH/32  passed through
- out_rs1_data, out_rs2_data  out  DATA_WIDTH  operands
- out_rd  out  ADDR_WIDTH  destination
- out_rd_we  out  1  instruction writes rd (rd != 0)
- stall_count  out  32  saturating count of hazard-stall cycles

## Operation
- Fields: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- uses_rs1: opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
- uses_rs2: opcode in {OP 0110011, STORE 0100011, BRANCH 1100011}.
- rd_we: opcode not STORE/BRANCH and rd != 0.
- Two slots: D (decode, holds instr/pc) and X (output register). Each slot is EMPTY or FULL.
- The D slot drives rf_read_addrs continuously; unused sources are still driven.
- Hazard for a used source rs != 0: pending[rs]=1, or X FULL with X.rd_we and X.rd==rs.
- WAW stall: D.rd_we and (pending[D.rd] or (X FULL with X.rd_we and X.rd==D.rd)).
- issue = D FULL and no hazard and (X EMPTY or out_ready).
- On issue, X captures D fields, rf_read_data[0/1] (0 if the source is unused) and rd/rd_we.
- in_ready = (D EMPTY or issue) and !flush. D loads on in_valid & in_ready.
- Scoreboard set: on the out_valid & out_ready handshake with out_rd_we, pending[out_rd] <= 1.
- Scoreboard clear: wb_valid with wb_addr != 0 clears pending[wb_addr]. If set and clear hit the same register in the same cycle, set wins.
- Because scoreboard bits are set only at handoff, flush never strands a pending bit.
- flush: D and X go EMPTY next edge and all input is rejected that cycle. The scoreboard is untouched, since older in-flight writes still retire.
- stall_count increments each cycle with D FULL and a hazard; it saturates at 0xFFFFFFFF.

## Timing
- Reset (rst_n low, asynchronous): D and X EMPTY, pending all 0, stall_count 0.
- Reset values of the other outputs: out_valid 0, out_* data 0, rf_read_addrs 0, in_ready 0.
- Reset release: in_ready is 1 in the first cycle after rst_n rises.
- Latency: 1 cycle from input accept to out_valid when there is no hazard.
- Throughput: 1 instruction/cycle with out_ready held high.
- RF writes land at the edge after wb_valid, so a reader stalls through the wb cycle itself. A dependent instruction issues the cycle after wb_valid, no bypass.
- X holds all out_* stable while out_valid & !out_ready.
- In a cycle where out_ready=1 and D is hazarded, X drains and goes EMPTY.

## Test plan
- Independent stream (addi x1; addi x2; add x3,x4,x5) with out_ready=1 -> out_valid one cycle after each accept, back-to-back, stall_count 0.
- RAW hazard:
  - Stimulus: add x5,x1,x2 handed off, then sub x6,x5,x3; wb_valid/wb_addr=5 pulsed 3 cycles later.
  - Required: sub stalls; it issues the cycle after wb_valid; out_rs1_data equals the newly written x5; stall_count=4.
- x0 and unused sources:
  - Stimulus: pending[x0] never set; lui x7 with rs1 field=5 while pending[5]=1.
  - Required: no stall; out_rs1_data=0.
- Backpressure: out_ready=0 for 5 cycles with 3 instructions offered -> X stable, D full, in_ready=0; order preserved on release.
- flush with D and X FULL (X.rd=9) -> both EMPTY next cycle, pending[9] stays 0, no input accepted that cycle.
- Async reset asserted mid-stall -> all outputs zero immediately, scoreboard cleared, normal accept after release.
